// File: rtl/jk_pkg.sv
// Shared JK definitions: drive encodings and the per-bit {J,K} derivation.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package jk_pkg;

    // {J,K} encodings as seen by a JK flip-flop
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // {J,K} that moves one stored bit from q_bit to next_bit.
    // Only set/reset/hold come out of here; toggle is never requested.
    function automatic logic [1:0] jk_drive(input logic q_bit, input logic next_bit);
        logic [1:0] jk;
        jk = JK_HOLD;
        if (next_bit && !q_bit) begin
            jk = JK_SET;
        end else if (!next_bit && q_bit) begin
            jk = JK_RST;
        end
        return jk;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Positive-edge JK flip-flop with complementary registered outputs.
// Latency: one clock from j/k to q/qb.
// Backpressure: none; state updates every rising edge.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (q=0, qb=1)
//   j,k  JK controls: 00 hold, 01 reset, 10 set, 11 toggle
//   q    stored bit
//   qb   complement of q, held in its own register
module jk_ff
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    // qb is a separate register that is always written alongside q,
    // so it never depends combinationally on q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end else begin
            case ({j, k})
                JK_SET: begin
                    q  <= 1'b1;
                    qb <= 1'b0;
                end
                JK_RST: begin
                    q  <= 1'b0;
                    qb <= 1'b1;
                end
                JK_TGL: begin
                    q  <= ~q;
                    qb <= ~qb;
                end
                default: begin
                    q  <= q;
                    qb <= qb;
                end
            endcase
        end
    end

endmodule

// File: rtl/jk_sync_counter.sv
// Up/down modulo-MOD counter whose state bits live in JK flip-flops.
// Latency: one clock from rst/load/en/up/d to q/qb; tc is combinational from q/en/up/load.
// Backpressure: none; en=0 with load=0 simply holds the count.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (q=0)
//   en    count enable
//   up    direction, 1 = increment, 0 = decrement
//   load  synchronous parallel load (clamped to MOD-1)
//   d     parallel load value
//   q     current count
//   qb    registered complement of q
//   tc    terminal count: the next enabled edge wraps
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    // One extra bit so MOD == 2**WIDTH is representable in compares.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO_Q  = '0;
    localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

    logic             at_max;
    logic             at_zero;
    logic             in_range;
    logic             d_in_range;
    logic [WIDTH-1:0] nxt;

    assign at_max     = (q == MAX_Q);
    assign at_zero    = (q == ZERO_Q);
    assign in_range   = ({1'b0, q} < MOD_EXT);
    assign d_in_range = ({1'b0, d} < MOD_EXT);

    // Required next count. Wrap is an explicit compare so non-power-of-two
    // moduli work; an out-of-range state (only via X/upset) is folded onto
    // the wrap target of the current direction.
    always_comb begin
        nxt = q;
        if (load) begin
            nxt = d_in_range ? d : MAX_Q;
        end else if (en) begin
            if (up) begin
                nxt = (at_max || !in_range) ? ZERO_Q : q + ONE_Q;
            end else begin
                nxt = (at_zero || !in_range) ? MAX_Q : q - ONE_Q;
            end
        end
    end

    assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

    // Reset is applied inside each flop, so nxt/JK need not consider rst.
    // When nxt == q (hold) every bit gets J=K=0.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [1:0] jk;

        assign jk = jk_drive(q[i], nxt[i]);

        jk_ff u_ff (
            .clk (clk),
            .rst (rst),
            .j   (jk[1]),
            .k   (jk[0]),
            .q   (q[i]),
            .qb  (qb[i])
        );
    end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Bench for jk_sync_counter: directed scenarios plus random traffic against
// a modular-arithmetic reference, on a MOD=10 and a full-range MOD=8 instance.
module tb_jk_sync_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a: WIDTH=4, MOD=10
    logic       rst_a = 1'b0, en_a = 1'b0, up_a = 1'b0, load_a = 1'b0;
    logic [3:0] d_a = '0, q_a, qb_a;
    logic       tc_a;
    // instance b: WIDTH=3, MOD=8
    logic       rst_b = 1'b0, en_b = 1'b0, up_b = 1'b0, load_b = 1'b0;
    logic [2:0] d_b = '0, q_b, qb_b;
    logic       tc_b;

    jk_sync_counter #(.WIDTH(4), .MOD(10)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .load(load_a),
        .d(d_a), .q(q_a), .qb(qb_a), .tc(tc_a)
    );

    jk_sync_counter #(.WIDTH(3), .MOD(8)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .load(load_b),
        .d(d_b), .q(q_b), .qb(qb_b), .tc(tc_b)
    );

    int   total = 0;
    int   bad   = 0;
    int   mq_a  = 0;
    int   mq_b  = 0;
    logic obs_tc_a, exp_tc_a, obs_tc_b, exp_tc_b;

    // Reference: next count straight from the rules, using modular arithmetic.
    function automatic int ref_next(int m, int modv, logic r, logic l, logic e, logic u, int dv);
        if (r)      return 0;
        if (l)      return (dv < modv) ? dv : modv - 1;
        if (!e)     return m;
        if (u)      return (m + 1) % modv;
        return (m + modv - 1) % modv;
    endfunction

    function automatic logic ref_tc(int m, int modv, logic l, logic e, logic u);
        return e && !l && ((u && m == modv - 1) || (!u && m == 0));
    endfunction

    // Drive one cycle on instance a: sample tc before the edge, advance the
    // model at the edge, then park the inputs at hold.
    task automatic step_a(input logic r, input logic l, input logic e, input logic u, input logic [3:0] dv);
        rst_a = r; load_a = l; en_a = e; up_a = u; d_a = dv;
        @(negedge clk);
        obs_tc_a = tc_a;
        exp_tc_a = ref_tc(mq_a, 10, l, e, u);
        @(posedge clk);
        mq_a = ref_next(mq_a, 10, r, l, e, u, int'(dv));
        #1;
        rst_a = 1'b0; load_a = 1'b0; en_a = 1'b0;
    endtask

    task automatic step_b(input logic r, input logic l, input logic e, input logic u, input logic [2:0] dv);
        rst_b = r; load_b = l; en_b = e; up_b = u; d_b = dv;
        @(negedge clk);
        obs_tc_b = tc_b;
        exp_tc_b = ref_tc(mq_b, 8, l, e, u);
        @(posedge clk);
        mq_b = ref_next(mq_b, 8, r, l, e, u, int'(dv));
        #1;
        rst_b = 1'b0; load_b = 1'b0; en_b = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step_a(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            step_b(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        end
        total++; if (q_a !== 4'd0)    begin bad++; $display("FAIL reset_q_a got=%b want=0000", q_a); end
        total++; if (qb_a !== 4'hF)   begin bad++; $display("FAIL reset_qb_a got=%b want=1111", qb_a); end
        total++; if (tc_a !== 1'b0)   begin bad++; $display("FAIL reset_tc_a got=%b want=0", tc_a); end
        total++; if (q_b !== 3'd0)    begin bad++; $display("FAIL reset_q_b got=%b want=000", q_b); end
        total++; if (qb_b !== 3'b111) begin bad++; $display("FAIL reset_qb_b got=%b want=111", qb_b); end
    endtask

    task automatic test_count_up();
        logic [3:0] want;
        for (int k = 0; k < 12; k++) begin
            step_a(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
            want = 4'((k + 1) % 10);
            total++; if (q_a !== want)   begin bad++; $display("FAIL up_q k=%0d got=%0d want=%0d", k, q_a, want); end
            total++; if (qb_a !== ~want) begin bad++; $display("FAIL up_qb k=%0d got=%b want=%b", k, qb_a, ~want); end
            total++; if (obs_tc_a !== ((k % 10) == 9)) begin
                bad++; $display("FAIL up_tc k=%0d got=%b want=%b", k, obs_tc_a, ((k % 10) == 9));
            end
        end
    endtask

    task automatic test_count_down();
        int exp_seq [5] = '{1, 0, 9, 8, 7};
        int pre_seq [5] = '{2, 1, 0, 9, 8};
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        total++; if (q_a !== 4'd2) begin bad++; $display("FAIL down_load got=%0d want=2", q_a); end
        for (int k = 0; k < 5; k++) begin
            step_a(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            total++; if (q_a !== 4'(exp_seq[k])) begin bad++; $display("FAIL down_q k=%0d got=%0d want=%0d", k, q_a, exp_seq[k]); end
            total++; if (obs_tc_a !== (pre_seq[k] == 0)) begin
                bad++; $display("FAIL down_tc k=%0d got=%b want=%b", k, obs_tc_a, (pre_seq[k] == 0));
            end
        end
    endtask

    task automatic test_load_clamp();
        logic [3:0] dvals [4] = '{4'd7, 4'd12, 4'd9, 4'd15};
        logic [3:0] wants [4] = '{4'd7, 4'd9, 4'd9, 4'd9};
        for (int k = 0; k < 4; k++) begin
            step_a(1'b0, 1'b1, 1'b1, 1'b1, dvals[k]);
            total++; if (q_a !== wants[k]) begin bad++; $display("FAIL load_q d=%0d got=%0d want=%0d", dvals[k], q_a, wants[k]); end
            total++; if (qb_a !== ~wants[k]) begin bad++; $display("FAIL load_qb d=%0d got=%b want=%b", dvals[k], qb_a, ~wants[k]); end
            total++; if (obs_tc_a !== 1'b0) begin bad++; $display("FAIL load_tc d=%0d got=%b want=0", dvals[k], obs_tc_a); end
        end
    endtask

    task automatic test_hold_dir();
        logic       ups   [3] = '{1'b1, 1'b0, 1'b1};
        logic [3:0] wants [3] = '{4'd6, 4'd5, 4'd6};
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
        for (int k = 0; k < 3; k++) begin
            step_a(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
            total++; if (q_a !== 4'd5) begin bad++; $display("FAIL hold_q k=%0d got=%0d want=5", k, q_a); end
        end
        for (int k = 0; k < 3; k++) begin
            step_a(1'b0, 1'b0, 1'b1, ups[k], 4'd0);
            total++; if (q_a !== wants[k]) begin bad++; $display("FAIL dir_q k=%0d got=%0d want=%0d", k, q_a, wants[k]); end
        end
    endtask

    task automatic test_reset_mid();
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
        step_a(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
        total++; if (q_a !== 4'd0)  begin bad++; $display("FAIL rstmid_q got=%0d want=0", q_a); end
        total++; if (qb_a !== 4'hF) begin bad++; $display("FAIL rstmid_qb got=%b want=1111", qb_a); end
        step_a(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        total++; if (q_a !== 4'd1)  begin bad++; $display("FAIL rstmid_resume got=%0d want=1", q_a); end
    endtask

    task automatic test_full_range();
        step_b(1'b0, 1'b1, 1'b0, 1'b0, 3'd7);
        total++; if (q_b !== 3'd7) begin bad++; $display("FAIL full_load got=%0d want=7", q_b); end
        step_b(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        total++; if (q_b !== 3'd0)      begin bad++; $display("FAIL full_upwrap got=%0d want=0", q_b); end
        total++; if (obs_tc_b !== 1'b1) begin bad++; $display("FAIL full_uptc got=%b want=1", obs_tc_b); end
        step_b(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        total++; if (q_b !== 3'd7)      begin bad++; $display("FAIL full_dnwrap got=%0d want=7", q_b); end
        total++; if (qb_b !== 3'd0)     begin bad++; $display("FAIL full_dnqb got=%b want=000", qb_b); end
        total++; if (obs_tc_b !== 1'b1) begin bad++; $display("FAIL full_dntc got=%b want=1", obs_tc_b); end
    endtask

    task automatic test_random();
        logic r, l, e, u;
        for (int k = 0; k < 300; k++) begin
            r = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 5) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom);
            step_a(r, l, e, u, 4'($urandom));
            total++; if (q_a !== 4'(mq_a)) begin bad++; $display("FAIL rnd_a_q k=%0d got=%0d want=%0d", k, q_a, mq_a); end
            total++; if (qb_a !== ~4'(mq_a)) begin bad++; $display("FAIL rnd_a_qb k=%0d got=%b want=%b", k, qb_a, ~4'(mq_a)); end
            total++; if (obs_tc_a !== exp_tc_a) begin bad++; $display("FAIL rnd_a_tc k=%0d got=%b want=%b", k, obs_tc_a, exp_tc_a); end
        end
        for (int k = 0; k < 300; k++) begin
            r = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 5) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom);
            step_b(r, l, e, u, 3'($urandom));
            total++; if (q_b !== 3'(mq_b)) begin bad++; $display("FAIL rnd_b_q k=%0d got=%0d want=%0d", k, q_b, mq_b); end
            total++; if (qb_b !== ~3'(mq_b)) begin bad++; $display("FAIL rnd_b_qb k=%0d got=%b want=%b", k, qb_b, ~3'(mq_b)); end
            total++; if (obs_tc_b !== exp_tc_b) begin bad++; $display("FAIL rnd_b_tc k=%0d got=%b want=%b", k, obs_tc_b, exp_tc_b); end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_hold_dir();
        test_reset_mid();
        test_full_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
